// File: rtl/random_request_arbiter.sv
// random_request_arbiter: round-robin sharing of one RandomGenerator among NUM_REQ requesters.
// Optional macro RANGE_CHECK_EN: a winner with min > max gets an error pulse instead of a sample.
module random_request_arbiter #(
    parameter int                NUM_REQ     = 4,
    parameter int                WIDTH       = 8,
    parameter int                RNG_LATENCY = 1,
    parameter logic [WIDTH-1:0]  SEED        = 8'd1,
    parameter int                INIT_CYCLES = 2
) (
    input  logic                         in_clock,
    input  logic                         in_reset,
    input  logic [NUM_REQ-1:0]           in_req,
    input  logic [NUM_REQ*WIDTH-1:0]     in_min_flat,
    input  logic [NUM_REQ*WIDTH-1:0]     in_max_flat,
    output logic [NUM_REQ-1:0]           out_grant,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_random,
    output logic [$clog2(NUM_REQ)-1:0]   out_owner,
    output logic                         out_error,
    output logic                         out_rng_reset,
    output logic                         out_rng_enable,
    output logic [WIDTH-1:0]             out_rng_seed,
    output logic [WIDTH-1:0]             out_rng_min,
    output logic [WIDTH-1:0]             out_rng_max,
    input  logic [WIDTH-1:0]             in_rng_random
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int CNT_W  = 3;

    typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, DELIVER} state_t;

    state_t                    state;
    logic [IDX_W-1:0]          ptr;
    logic [INIT_W-1:0]         init_cnt;
    logic [CNT_W-1:0]          wait_cnt;
    logic [IDX_W-1:0]          win_idx;
    logic                      win_found;
    logic signed [WIDTH-1:0]   win_min;
    logic signed [WIDTH-1:0]   win_max;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    // Round-robin search starting at ptr; the first set bit wins.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && in_req[wrap_idx(ptr, i)]) begin
                win_idx   = wrap_idx(ptr, i);
                win_found = 1'b1;
            end
        end
    end

    assign win_min      = in_min_flat[win_idx*WIDTH +: WIDTH];
    assign win_max      = in_max_flat[win_idx*WIDTH +: WIDTH];
    assign out_rng_seed = SEED;

`ifdef RANGE_CHECK_EN
    logic range_bad;
    logic error_q;
    assign range_bad = (win_min > win_max);
    assign out_error = error_q;
`else
    assign out_error = 1'b0;
`endif

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state          <= INIT;
            ptr            <= '0;
            init_cnt       <= '0;
            wait_cnt       <= '0;
            out_valid      <= 1'b0;
            out_grant      <= '0;
            out_random     <= '0;
            out_owner      <= '0;
            out_rng_enable <= 1'b0;
            out_rng_min    <= '0;
            out_rng_max    <= '0;
            out_rng_reset  <= 1'b1;
`ifdef RANGE_CHECK_EN
            error_q        <= 1'b0;
`endif
        end else begin
            case (state)
                INIT: begin
                    if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
                        state         <= IDLE;
                        out_rng_reset <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (win_found) begin
                        out_owner   <= win_idx;
                        out_rng_min <= win_min;
                        out_rng_max <= win_max;
`ifdef RANGE_CHECK_EN
                        // An inverted range never reaches the generator.
                        if (range_bad) begin
                            state     <= DELIVER;
                            out_grant <= onehot(win_idx);
                            error_q   <= 1'b1;
                        end else
`endif
                        begin
                            state          <= ISSUE;
                            out_rng_enable <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    out_rng_enable <= 1'b0;
                    wait_cnt       <= '0;
                    state          <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == CNT_W'(RNG_LATENCY - 1)) begin
                        out_random <= in_rng_random;
                        out_valid  <= 1'b1;
                        out_grant  <= onehot(out_owner);
                        state      <= DELIVER;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DELIVER: begin
                    out_valid <= 1'b0;
                    out_grant <= '0;
`ifdef RANGE_CHECK_EN
                    error_q   <= 1'b0;
`endif
                    ptr       <= wrap_idx(out_owner, 1);
                    state     <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_random_request_arbiter.sv
// Randomized bench for random_request_arbiter with a transaction-level reference model
// and a stand-in generator; honours RANGE_CHECK_EN when defined.
module tb_random_request_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int L  = 1;
    localparam int IC = 2;
    localparam logic [W-1:0] SEED = 8'd1;
`ifdef RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N*W-1:0] minf  = '0;
    logic [N*W-1:0] maxf  = '0;
    logic [N-1:0]   grant;
    logic           valid;
    logic [W-1:0]   rnd;
    logic [1:0]     owner;
    logic           err;
    logic           rng_rst;
    logic           rng_en;
    logic [W-1:0]   rng_seed;
    logic [W-1:0]   rng_min;
    logic [W-1:0]   rng_max;
    logic [W-1:0]   rng_out = '0;

    int checks = 0;
    int errors = 0;

    random_request_arbiter #(
        .NUM_REQ(N), .WIDTH(W), .RNG_LATENCY(L), .SEED(SEED), .INIT_CYCLES(IC)
    ) dut (
        .in_clock(clk), .in_reset(rst_n), .in_req(req),
        .in_min_flat(minf), .in_max_flat(maxf),
        .out_grant(grant), .out_valid(valid), .out_random(rnd), .out_owner(owner),
        .out_error(err), .out_rng_reset(rng_rst), .out_rng_enable(rng_en),
        .out_rng_seed(rng_seed), .out_rng_min(rng_min), .out_rng_max(rng_max),
        .in_rng_random(rng_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] gen_pick(input logic [W-1:0] lo, input logic [W-1:0] hi);
        int span;
        if ($signed(hi) < $signed(lo)) return lo;
        span = int'($signed(hi)) - int'($signed(lo)) + 1;
        return W'(int'($signed(lo)) + int'($urandom_range(span - 1, 0)));
    endfunction

    task automatic set_range(input int i, input int lo, input int hi);
        minf[i*W +: W] = W'(lo);
        maxf[i*W +: W] = W'(hi);
    endtask

    // Reference model: each transaction is a start cycle plus scheduled issue/deliver cycles.
    int         cyc = 0, init_left = IC, ptr_m = 0, own_m = 0, c_issue = -1, c_del = -1;
    bit         act_m = 1'b0, err_m = 1'b0;
    logic [W-1:0] min_m = '0, max_m = '0, rnd_m = '0, gen_last = '0;

    always @(posedge clk) begin
        int cur;
        cur = cyc;
        cyc = cyc + 1;
        if (rng_en) begin
            gen_last = gen_pick(rng_min, rng_max);
            rng_out <= gen_last;
        end else begin
            rng_out <= W'($urandom);
        end
        if (!rst_n) begin
            init_left = IC; act_m = 1'b0; err_m = 1'b0; ptr_m = 0; own_m = 0;
            min_m = '0; max_m = '0; rnd_m = '0; c_issue = -1; c_del = -1;
        end else if (init_left > 0) begin
            init_left = init_left - 1;
        end else if (act_m && cur == c_del) begin
            act_m = 1'b0;
            ptr_m = (own_m + 1) % N;
        end else if (!act_m && req != '0) begin
            for (int k = N - 1; k >= 0; k--)
                if (req[(ptr_m + k) % N]) own_m = (ptr_m + k) % N;
            min_m   = minf[own_m*W +: W];
            max_m   = maxf[own_m*W +: W];
            err_m   = RC && ($signed(min_m) > $signed(max_m));
            c_issue = err_m ? -1 : cyc;
            c_del   = err_m ? cyc : cyc + 1 + L;
            act_m   = 1'b1;
        end
        if (act_m && !err_m && cyc == c_del) rnd_m = gen_last;
    end

    always @(negedge clk) begin
        logic         dl;
        logic [N-1:0] eg;
        if (!rst_n) begin
            chk("rst_grant", grant, 0);     chk("rst_valid", valid, 0);
            chk("rst_random", rnd, 0);      chk("rst_owner", owner, 0);
            chk("rst_error", err, 0);       chk("rst_enable", rng_en, 0);
            chk("rst_min", rng_min, 0);     chk("rst_max", rng_max, 0);
            chk("rst_rngreset", rng_rst, 1); chk("rst_seed", rng_seed, SEED);
        end else begin
            dl = act_m && (cyc == c_del);
            eg = dl ? (N'(1) << own_m) : '0;
            chk("cmp_rngreset", rng_rst, init_left > 0);
            chk("cmp_enable", rng_en, act_m && (cyc == c_issue));
            chk("cmp_valid", valid, dl && !err_m);
            chk("cmp_error", err, dl && err_m);
            chk("cmp_grant", grant, eg);
            chk("cmp_owner", owner, own_m);
            chk("cmp_random", rnd, rnd_m);
            chk("cmp_min", rng_min, min_m);
            chk("cmp_max", rng_max, max_m);
            chk("cmp_seed", rng_seed, SEED);
        end
    end

    // One isolated request from requester idx; DUT must be idle on entry.
    task automatic single(input int idx, input int lo, input int hi, input bit exp_err);
        int t_hit = -1, en_cnt = 0, en_lo = 0, en_hi = 0, r = 0;
        logic [N-1:0] g = '0;
        logic v = 1'b0, e = 1'b0;
        set_range(idx, lo, hi);
        req = N'(1) << idx;
        for (int t = 1; t <= 12 && t_hit < 0; t++) begin
            @(negedge clk);
            if (rng_en) begin
                en_cnt++;
                en_lo = int'($signed(rng_min));
                en_hi = int'($signed(rng_max));
            end
            if (grant != '0) begin
                t_hit = t; g = grant; v = valid; e = err; r = int'($signed(rnd));
                chk("model_owner", own_m, idx);
                req = '0;
            end
        end
        req = '0;
        chk("single_latency", t_hit, exp_err ? 1 : 2 + L);
        chk("single_grant", g, N'(1) << idx);
        chk("single_valid", v, !exp_err);
        chk("single_error", e, exp_err);
        chk("single_enables", en_cnt, exp_err ? 0 : 1);
        if (!exp_err) begin
            chk("single_rng_min", en_lo, lo);
            chk("single_rng_max", en_hi, hi);
            if (lo <= hi) chk("single_in_range", (r >= lo) && (r <= hi), 1);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int hits, n, fo;
        int order[$];
        int gcyc[$];
        int drop[N];
        for (int i = 0; i < N; i++) set_range(i, -50, 50);

        // Reset and INIT window with all requesters asserting.
        req = 4'b1111;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        hits = 0; n = 0;
        repeat (3) begin
            @(negedge clk);
            if (rng_rst) hits++;
            if (grant != '0) n++;
        end
        chk("init_reset_cycles", hits, IC);
        chk("init_no_grant", n, 0);
        chk("init_seed", rng_seed, 1);
        req = '0;
        repeat (8) @(negedge clk);

        single(2, -20, -10, 1'b0);
        single(3, 0, 100, 1'b0);
        chk("model_ptr_wrap", ptr_m, 0);

        // All requesters, each dropping for the cycle after its own grant.
        for (int i = 0; i < N; i++) drop[i] = 0;
        req = 4'b1111;
        for (int t = 0; t < 60 && order.size() < 5; t++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (drop[i] > 0) drop[i]--;
            if (grant != '0) begin
                for (int i = 0; i < N; i++) if (grant[i]) begin order.push_back(i); drop[i] = 2; end
                gcyc.push_back(t);
            end
            for (int i = 0; i < N; i++) req[i] = (drop[i] == 0);
        end
        req = '0;
        chk("rr_count", order.size(), 5);
        for (int i = 0; i < order.size(); i++) chk("rr_order", order[i], i % N);
        for (int i = 1; i < gcyc.size(); i++) chk("rr_gap", gcyc[i] - gcyc[i-1], L + 3);
        repeat (2) @(negedge clk);

        // Reset during WAIT: ptr is 1, so requester 3 wins first, then reset clears ptr.
        req = 4'b1001;
        @(negedge clk);
        chk("pre_reset_enable", rng_en, 1);
        chk("pre_reset_owner", owner, 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        n = 0;
        repeat (3) begin @(negedge clk); if (valid) n++; end
        @(posedge clk);
        #2 rst_n = 1'b1;
        fo = -1;
        for (int t = 0; t < 20 && fo < 0; t++) begin
            @(negedge clk);
            if (grant != '0) begin fo = int'(owner); chk("after_reset_grant", grant, 4'b0001); end
            else if (valid) n++;
        end
        req = '0;
        chk("abort_no_valid", n, 0);
        chk("after_reset_owner", fo, 0);
        repeat (4) @(negedge clk);

        // Inverted range on requester 1.
        single(1, 5, 2, RC);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #2;
            if (!rst_n) rst_n = ($urandom_range(1, 0) == 1);
            else if ($urandom_range(299, 0) == 0) rst_n = 1'b0;
            @(negedge clk);
            req = N'($urandom & $urandom);
            if ($urandom_range(7, 0) == 0) begin
                int lo, hi, i, tmp;
                i  = int'($urandom_range(N - 1, 0));
                lo = int'($urandom_range(255, 0)) - 128;
                hi = int'($urandom_range(255, 0)) - 128;
                if ($urandom_range(7, 0) != 0 && lo > hi) begin tmp = lo; lo = hi; hi = tmp; end
                set_range(i, lo, hi);
            end
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        req = '0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/random_request_arbiter.md
# random_request_arbiter

Shares one RandomGenerator instance among NUM_REQ solver requesters, each with its own signed [min,max] range. Seeds the generator after reset, arbitrates pending requests round-robin, drives the generator's enable and range inputs for the winner, and returns one sample per grant with a valid pulse and owner index. Sits between the MCMC variable-update units and the shared random generator.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- WIDTH, 8: sample and range width, signed
- RNG_LATENCY, 1: cycles from the generator's enable cycle to a valid sample (1..4)
- SEED, 8'd1: seed driven to the generator during INIT
- INIT_CYCLES, 2: cycles the generator is held in reset after our reset releases

- in_clock  in  1  clock
- in_reset  in  1  asynchronous, active-low reset
- in_req  in  NUM_REQ  level request, one bit per requester
- in_min_flat  in  NUM_REQ*WIDTH  signed min of requester i at bits [i*WIDTH +: WIDTH]
- in_max_flat  in  NUM_REQ*WIDTH  signed max, same packing
- out_grant  out  NUM_REQ  one-hot, high only in DELIVER
- out_valid  out  1  sample valid, high only in DELIVER
- out_random  out  WIDTH  signed sample, held until next DELIVER
- out_owner  out  $clog2(NUM_REQ)  index of granted requester
- out_error  out  1  range-error pulse (RANGE_CHECK_EN only, else tied 0)
- out_rng_reset  out  1  to generator in_reset (active-high)
- out_rng_enable  out  1  to generator in_enable
- out_rng_seed  out  WIDTH  to generator in_seed, constant SEED
- out_rng_min, out_rng_max  out  WIDTH  to generator in_min/in_max
- in_rng_random  in  WIDTH  from generator out_random

## Operation
- FSM states: INIT, IDLE, ISSUE, WAIT, DELIVER.
- INIT: out_rng_reset=1 for INIT_CYCLES cycles after in_reset deasserts, then IDLE. Requests ignored.
- IDLE: if any in_req bit set, pick winner = first set bit searching from ptr upward with wrap; latch index and winner's min/max onto out_rng_min/max; go ISSUE. Else stay.
- ISSUE: out_rng_enable=1 for exactly one cycle; go WAIT.
- WAIT: counter runs RNG_LATENCY cycles; on the final WAIT edge register in_rng_random into out_random; go DELIVER.
- DELIVER: out_valid=1, out_grant[owner]=1 for one cycle; ptr <= (owner+1) mod NUM_REQ; go IDLE. Requests are never sampled in DELIVER (requester drops in_req the cycle after its grant).
- out_rng_min/max hold latched values outside ISSUE/WAIT; out_rng_enable is 0 outside ISSUE.
- in_req deasserted after being latched does not abort the transaction; sample still delivered.
- Ranges passed verbatim; no arithmetic in this block.

## Timing
- Reset (in_reset=0): state INIT, ptr 0, counters 0, out_valid 0, out_grant 0, out_random 0, out_owner 0, out_error 0, out_rng_enable 0, out_rng_min/max 0, out_rng_reset 1, out_rng_seed SEED.
- Latency: request sampled in IDLE cycle n -> ISSUE n+1 -> WAIT n+2..n+1+RNG_LATENCY -> out_valid in cycle n+2+RNG_LATENCY.
- Throughput: one sample per RNG_LATENCY+3 cycles under continuous demand.
- Reset mid-transaction: immediate return to INIT; no grant or valid for the aborted request; ptr returns to 0.
- All requesters requesting: each served exactly once per NUM_REQ grants.

## Configuration
- RANGE_CHECK_EN defined: in IDLE, if winner's min > max (signed), skip ISSUE/WAIT; next cycle is DELIVER with out_grant[owner]=1, out_error=1, out_valid=0, out_random unchanged; ptr advances.
- Not defined: no check, out_error tied 0, ranges forwarded unchanged.

## Test plan
- Reset, then release: out_rng_reset high exactly INIT_CYCLES=2 cycles with out_rng_seed=1; no grants though in_req=4'b1111 held.
- Single requester 2, min=-20, max=-10: out_rng_enable one pulse, out_rng_min/max=-20/-10, out_valid and out_grant=4'b0100 exactly 3 cycles after IDLE sampling, out_random in [-20,-10].
- in_req=4'b1111 held (each drops one cycle after own grant and re-raises): grant order 0,1,2,3,0; never two grants without an idle cycle between.
- in_reset pulled low during WAIT: no out_valid; after INIT, pending requester 0 served first.
- RANGE_CHECK_EN, requester 1 min=5 max=2: out_error=1, out_grant=4'b0010, out_valid=0, out_rng_enable never asserted; without macro the same stimulus gives normal valid sample and out_error=0.
